// File: rtl/gin_bus.sv
// gin_bus: global-input-network bus. One upstream packet stream is delivered,
// by tag-to-ID matching, to SLV_NUM slave ports. The tag is stripped, and each
// slave port has one register stage with a valid/ready handshake.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_data      input packet {tag, payload}
//   i_valid     input packet valid
//   o_ready     bus accepts the packet this cycle (combinational)
//   o_data      slave k payload at [k*PACKET_OUT_BITWIDTH +: PACKET_OUT_BITWIDTH]
//   i_ready     bit k: slave k accepts its output
//   o_valid     bit k: slave k output valid
//   i_id        slave k ID at [k*ID_BITWIDTH +: ID_BITWIDTH]
//   i_id_valid  load every slave ID from i_id
module gin_bus #(
    parameter int unsigned ID_BITWIDTH         = 4,
    parameter int unsigned PACKET_IN_BITWIDTH  = 12,
    parameter int unsigned PACKET_OUT_BITWIDTH = 8,
    parameter int unsigned SLV_NUM             = 6
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [PACKET_IN_BITWIDTH-1:0]          i_data,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    output logic [SLV_NUM*PACKET_OUT_BITWIDTH-1:0] o_data,
    input  logic [SLV_NUM-1:0]                     i_ready,
    output logic [SLV_NUM-1:0]                     o_valid,
    input  logic [SLV_NUM*ID_BITWIDTH-1:0]         i_id,
    input  logic                                   i_id_valid
);

    logic [SLV_NUM-1:0][ID_BITWIDTH-1:0]         id_q, id_d;
    logic [SLV_NUM-1:0]                          valid_q, valid_d;
    logic [SLV_NUM-1:0][PACKET_OUT_BITWIDTH-1:0] data_q, data_d;

    logic [ID_BITWIDTH-1:0]         tag;
    logic [PACKET_OUT_BITWIDTH-1:0] payload;
    logic [SLV_NUM-1:0]             match;
    logic [SLV_NUM-1:0]             slot_free;
    logic [SLV_NUM-1:0]             load;
    logic                           ready_c;
    logic                           accept;

    // Split the packet into its routing tag and its payload.
    assign tag     = i_data[PACKET_IN_BITWIDTH-1 -: ID_BITWIDTH];
    assign payload = i_data[PACKET_OUT_BITWIDTH-1:0];

    // Match against the current IDs. A blocked matched slot stalls the whole
    // packet, so multicast delivery is all-or-nothing.
    always_comb begin
        match     = '0;
        slot_free = '0;
        for (int unsigned k = 0; k < SLV_NUM; k++) begin
            match[k]     = (id_q[k] == tag);
            slot_free[k] = !valid_q[k] || i_ready[k];
        end
        ready_c = &(~match | slot_free);
        accept  = i_valid && ready_c;
        load    = accept ? match : '0;
    end

    // Next state: an ID load takes effect next cycle. A slot either loads new
    // data or holds its data, and its valid clears once the slave consumes it.
    always_comb begin
        id_d    = id_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (i_id_valid) begin
            id_d = i_id;
        end
        for (int unsigned k = 0; k < SLV_NUM; k++) begin
            if (load[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = payload;
            end else if (i_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_q    <= '0;
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            id_q    <= id_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_ready = ready_c;
    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_gin_bus.sv
// Directed bench for gin_bus: reset, ID config, unicast, backpressure,
// multicast, ID load racing a packet, no-match drop, streaming, mid-transfer reset.
module tb_gin_bus;

    localparam int unsigned IDW = 4;
    localparam int unsigned PIW = 12;
    localparam int unsigned POW = 8;
    localparam int unsigned NS  = 6;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [PIW-1:0]    i_data;
    logic              i_valid;
    logic              o_ready;
    logic [NS*POW-1:0] o_data;
    logic [NS-1:0]     i_ready;
    logic [NS-1:0]     o_valid;
    logic [NS*IDW-1:0] i_id;
    logic              i_id_valid;

    int n_checks = 0;
    int n_fail   = 0;

    gin_bus #(
        .ID_BITWIDTH(IDW),
        .PACKET_IN_BITWIDTH(PIW),
        .PACKET_OUT_BITWIDTH(POW),
        .SLV_NUM(NS)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_data(i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_data(o_data),
        .i_ready(i_ready),
        .o_valid(o_valid),
        .i_id(i_id),
        .i_id_valid(i_id_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst      = 1'b1;
        i_data     = '0;
        i_valid    = 1'b0;
        i_ready    = '0;
        i_id       = '0;
        i_id_valid = 1'b0;

        // Reset
        repeat (10) step();
        check("rst_valid", 48'(o_valid), 48'h0);
        check("rst_data",  48'(o_data),  48'h0);
        check("rst_ready", 48'(o_ready), 48'h1);
        i_rst = 1'b0;
        step();

        // ID config: slot 5 gets ID 0, ..., slot 0 gets ID 5
        i_id       = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        i_id_valid = 1'b1;
        step();
        i_id_valid = 1'b0;

        // Unicast tag 5 -> slot 0
        i_data  = 12'h500;
        i_valid = 1'b1;
        i_ready = 6'b111111;
        #1 check("uni_ready", 48'(o_ready), 48'h1);
        step();
        i_valid = 1'b0;
        i_ready = 6'b000000;
        check("uni_valid", 48'(o_valid), 48'h01);
        check("uni_data0", 48'(o_data[7:0]), 48'h00);
        step();
        check("uni_hold", 48'(o_valid), 48'h01);
        i_ready = 6'b000001;
        step();
        check("uni_consume", 48'(o_valid), 48'h00);

        // Backpressure on slot 0
        i_ready = 6'b000000;
        i_data  = 12'h5AA;
        i_valid = 1'b1;
        step();
        check("bp_first", 48'(o_data[7:0]), 48'hAA);
        i_data = 12'h5BB;
        #1 check("bp_stall_ready", 48'(o_ready), 48'h0);
        step();
        check("bp_hold_data",  48'(o_data[7:0]), 48'hAA);
        check("bp_hold_valid", 48'(o_valid), 48'h01);
        i_ready = 6'b000001;
        #1 check("bp_release_ready", 48'(o_ready), 48'h1);
        step();
        i_valid = 1'b0;
        i_ready = 6'b000000;
        check("bp_new_data",  48'(o_data[7:0]), 48'hBB);
        check("bp_new_valid", 48'(o_valid), 48'h01);
        i_ready = 6'b111111;
        step();
        check("bp_drain", 48'(o_valid), 48'h00);

        // Multicast: all IDs 3
        i_id       = {6{4'd3}};
        i_id_valid = 1'b1;
        step();
        i_id_valid = 1'b0;
        i_data  = 12'h35A;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        check("mc_valid", 48'(o_valid), 48'h3F);
        check("mc_data",  48'(o_data), {6{8'h5A}});
        i_ready = 6'b111011;
        i_data  = 12'h3C3;
        i_valid = 1'b1;
        #1 check("mc_block_ready", 48'(o_ready), 48'h0);
        step();
        i_valid = 1'b0;
        check("mc_block_valid", 48'(o_valid), 48'h04);
        check("mc_block_data",  48'(o_data), {6{8'h5A}});
        i_ready = 6'b111111;
        step();
        check("mc_drain", 48'(o_valid), 48'h00);

        // ID load in the same edge as a packet: old IDs (all 3) are used
        i_id       = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        i_id_valid = 1'b1;
        i_data     = 12'h377;
        i_valid    = 1'b1;
        step();
        i_id_valid = 1'b0;
        i_valid    = 1'b0;
        check("race_valid", 48'(o_valid), 48'h3F);
        check("race_data",  48'(o_data), {6{8'h77}});
        step();
        check("race_drain", 48'(o_valid), 48'h00);

        // No match: tag 9
        i_data  = 12'h912;
        i_valid = 1'b1;
        #1 check("nm_ready", 48'(o_ready), 48'h1);
        step();
        i_valid = 1'b0;
        check("nm_valid", 48'(o_valid), 48'h00);

        // Streaming tags 0..3, payload 0x10+t, lands in slot 5-t
        for (int t = 0; t < 4; t++) begin
            i_data  = {4'(t), 8'(8'h10 + t)};
            i_valid = 1'b1;
            #1 check("st_ready", 48'(o_ready), 48'h1);
            step();
            check("st_valid", 48'(o_valid), 48'(6'b1 << (5 - t)));
            check("st_data",  48'(o_data[(5 - t) * 8 +: 8]), 48'(8'h10 + t));
        end
        i_valid = 1'b0;
        step();
        check("st_drain", 48'(o_valid), 48'h00);

        // Reset mid-transfer discards pending outputs and clears IDs
        i_ready = 6'b000000;
        i_data  = 12'h2EE;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        check("mr_pending", 48'(o_valid), 48'h08);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check("mr_valid", 48'(o_valid), 48'h00);
        check("mr_data",  48'(o_data),  48'h0);
        i_ready = 6'b111111;
        i_data  = 12'h0C4;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        check("mr_id_zero_valid", 48'(o_valid), 48'h3F);
        check("mr_id_zero_data",  48'(o_data), {6{8'hC4}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gin_bus.md
Name: gin_bus

Overview:
- Global-input-network bus: one upstream packet stream is delivered to SLV_NUM slaves (PEs / downstream buses) by tag-to-ID matching.
- Each slave holds a programmable ID, loaded in one shot by the top controller.
- An incoming packet carries a tag. It is delivered, multicast, to every slave whose ID equals the tag, with the tag stripped.
- One register stage per slave output, with valid/ready handshakes on both sides.

Parameters:
- ID_BITWIDTH, 4, width of tag and of each slave ID.
- PACKET_IN_BITWIDTH, 12, input packet width = ID_BITWIDTH + PACKET_OUT_BITWIDTH.
- PACKET_OUT_BITWIDTH, 8, payload width delivered to slaves.
- SLV_NUM, 6, number of slave ports.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_data  in  PACKET_IN_BITWIDTH  input packet: tag = [PACKET_IN_BITWIDTH-1 -: ID_BITWIDTH], payload = [PACKET_OUT_BITWIDTH-1:0].
- i_valid  in  1  input packet valid.
- o_ready  out  1  bus can accept the packet this cycle.
- o_data  out  SLV_NUM*PACKET_OUT_BITWIDTH  slave k payload at [k*PACKET_OUT_BITWIDTH +: PACKET_OUT_BITWIDTH].
- i_ready  in  SLV_NUM  bit k: slave k accepts.
- o_valid  out  SLV_NUM  bit k: slave k output valid.
- i_id  in  SLV_NUM*ID_BITWIDTH  slave k ID at [k*ID_BITWIDTH +: ID_BITWIDTH].
- i_id_valid  in  1  load all IDs from i_id.

Behaviour:
- Reset (synchronous, active-high): all ID registers = 0, o_valid = 0, o_data = 0. o_ready is combinational and is 1 after reset. Reset mid-transfer discards all pending outputs.
- ID config: when i_id_valid = 1 at a rising edge, all SLV_NUM ID registers load from i_id. The new IDs are used from the next cycle.
- Simultaneous ID load and packet acceptance: the packet is matched against the old IDs.
- Match: match[k] = (id_reg[k] == tag), evaluated combinationally.
- Slot free: slot k is free when !o_valid[k] || i_ready[k].
- o_ready = AND over k of (!match[k] || slot k free). This is combinational from the tag, o_valid and i_ready.
- Accept when i_valid && o_ready. On the next edge, for every matched k: o_valid[k] <= 1 and o_data[k] <= payload.
- Multicast: several slaves sharing one ID all receive the packet in the same cycle. Delivery is atomic: all matched slots or none.
- No matching slave: the packet is accepted (o_ready = 1) and dropped.
- Slave handshake: o_valid[k] && i_ready[k] at an edge consumes the output. o_valid[k] then clears unless a new matched packet is loaded in the same edge, in which case it stays 1 with the new data.
- o_data[k] holds its value while o_valid[k] = 1 and i_ready[k] = 0 (no overwrite).
- Unmatched slots are unaffected by an accepted packet.
- Latency: 1 cycle from input acceptance to o_valid. Full throughput (1 packet/cycle) when matched slaves are always ready.
- i_valid = 0: no state change except slave consumption.

Test Plan:
- Reset: hold i_rst 10 cycles -> o_valid = 6'b0, o_data = 0, o_ready = 1.
- ID config plus unicast: i_id = {4'd0,4'd1,4'd2,4'd3,4'd4,4'd5} with i_id_valid for 1 cycle. Then i_data = 12'h500 (tag 5, payload 8'h00), i_valid = 1, i_ready = 6'b111111 for 1 cycle -> next cycle o_valid = 6'b000001, o_data[7:0] = 8'h00. o_valid[0] stays 1 while i_ready = 0; a later i_ready[0] = 1 clears it.
- Backpressure: slave 0 holds valid 8'hAA with i_ready[0] = 0; present tag 5 payload 8'hBB -> o_ready = 0, o_data[7:0] stays 8'hAA. Raise i_ready[0] -> o_ready = 1, 8'hBB is delivered the next cycle.
- Multicast: IDs all 4'd3; send tag 3 payload 8'h5A -> o_valid = 6'b111111 with every slot 8'h5A. With one slot blocked -> o_ready = 0 and no slot loads.
- No match: IDs 0..5; send tag 4'd9 -> o_ready = 1, o_valid stays 0.
- Streaming: IDs 0..5, i_ready all 1; send tags 0,1,2,3 on consecutive cycles -> o_valid one-hot bits 5,4,3,2 on consecutive cycles with matching payloads, o_ready constantly 1.
